// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: stereo FIFO in front of an SCLK/WS/SD serializer clocked from clk.
// Optional saturating underflow counter enabled by defining I2S_TX_UNDERFLOW_CNT_EN.
module i2s_tx_serializer #(
  parameter int AUDIO_WIDTH_P = 24,
  parameter int SCLK_DIV_P    = 4,
  parameter int FIFO_DEPTH_P  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [AUDIO_WIDTH_P-1:0] ing_left,
  input  logic signed [AUDIO_WIDTH_P-1:0] ing_right,
  input  logic                            ing_valid,
  output logic                            ing_ready,
  output logic                            i2s_sclk,
  output logic                            i2s_ws,
  output logic                            i2s_sd,
  input  logic                            cr_tx_enable,
  input  logic                            cr_underflow_clr,
  output logic                            sr_underflow,
  output logic [15:0]                     sr_underflow_cnt
);

  localparam int FW    = 2 * AUDIO_WIDTH_P;
  localparam int KW    = $clog2(FW);
  localparam int DIV_W = (SCLK_DIV_P > 1) ? $clog2(SCLK_DIV_P) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH_P);

  logic [FW-1:0]    mem [FIFO_DEPTH_P];
  logic [PTR_W:0]   wr_ptr, rd_ptr, fill;
  logic             empty, full, push, pop;
  logic             active, running, sclk, ws, sd, underflow;
  logic [DIV_W-1:0] div;
  logic [KW-1:0]    k, k_nx;
  logic [FW-1:0]    sr;
  logic             div_wrap, fall, frame_start;

  assign fill        = wr_ptr - rd_ptr;
  assign empty       = (fill == '0);
  assign full        = (fill == (PTR_W+1)'(FIFO_DEPTH_P));
  assign ing_ready   = active && !full;
  assign push        = ing_valid && ing_ready && cr_tx_enable;
  assign div_wrap    = (div == DIV_W'(SCLK_DIV_P - 1));
  assign fall        = div_wrap && sclk;
  assign k_nx        = (!running || k == KW'(FW - 1)) ? '0 : k + 1'b1;
  assign frame_start = fall && (k_nx == '0);
  // A pop on a frame start sees the pre-edge FIFO, so a same-cycle push into an empty FIFO waits
  assign pop         = frame_start && !empty;

  assign i2s_sclk     = sclk;
  assign i2s_ws       = ws;
  assign i2s_sd       = sd;
  assign sr_underflow = underflow;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {ing_left, ing_right};
  end

  // Shifter holds {left,right}; its MSB after 2W-1 shifts is right[0], sent at the next k=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0; running <= 1'b0; div <= '0; sclk <= 1'b0; ws <= 1'b0; sd <= 1'b0;
      k <= '0; sr <= '0; wr_ptr <= '0; rd_ptr <= '0; underflow <= 1'b0;
    end else if (!cr_tx_enable) begin
      active <= 1'b0; running <= 1'b0; div <= '0; sclk <= 1'b0; ws <= 1'b0; sd <= 1'b0;
      k <= '0; sr <= '0; wr_ptr <= '0; rd_ptr <= '0; underflow <= 1'b0;
    end else begin
      active    <= 1'b1;
      underflow <= 1'b0;
      if (div_wrap) begin
        div  <= '0;
        sclk <= ~sclk;
      end else begin
        div <= div + 1'b1;
      end
      if (fall) begin
        running <= 1'b1;
        k       <= k_nx;
        ws      <= (k_nx >= KW'(AUDIO_WIDTH_P));
        sd      <= sr[FW-1];
        if (k_nx == '0) begin
          sr        <= empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
          underflow <= empty;
        end else begin
          sr <= {sr[FW-2:0], 1'b0};
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt;
  logic        uf_set;

  assign uf_set           = cr_tx_enable && frame_start && empty;
  assign sr_underflow_cnt = uf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_cnt <= '0;
    end else if (cr_underflow_clr) begin
      uf_cnt <= '0;
    end else if (uf_set && uf_cnt != 16'hFFFF) begin
      uf_cnt <= uf_cnt + 1'b1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr       = cr_underflow_clr;
  assign sr_underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: random/directed pushes, frame-level FIFO model and an I2S receiver.
module tb_i2s_tx_serializer;
  localparam int W = 24;
  localparam int D = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n, ing_valid, ing_ready, i2s_sclk, i2s_ws, i2s_sd;
  logic cr_tx_enable, cr_underflow_clr, sr_underflow;
  logic signed [W-1:0] ing_left, ing_right;
  logic [15:0] sr_underflow_cnt;

  i2s_tx_serializer #(.AUDIO_WIDTH_P(W), .SCLK_DIV_P(D), .FIFO_DEPTH_P(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ing_left(ing_left), .ing_right(ing_right),
    .ing_valid(ing_valid), .ing_ready(ing_ready), .i2s_sclk(i2s_sclk), .i2s_ws(i2s_ws),
    .i2s_sd(i2s_sd), .cr_tx_enable(cr_tx_enable), .cr_underflow_clr(cr_underflow_clr),
    .sr_underflow(sr_underflow), .sr_underflow_cnt(sr_underflow_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs as seen by the active edge
  logic s_push, s_en, s_clr;
  logic [2*W-1:0] s_pair;
  always @(posedge clk) begin
    s_push <= ing_valid && ing_ready;
    s_en   <= cr_tx_enable;
    s_clr  <= cr_underflow_clr;
    s_pair <= {ing_left, ing_right};
  end

  // Reference: c = enabled edges since enable; SCLK = (c/D)%2; every 2D edges is one falling
  // event, k = (falls-1) mod 2W; frame start at k=0 pops the queue or emits a zero pair.
  int c = 0;
  int cur_k = -1;
  int pairs = 0;
  logic en_last = 1'b0;
  logic [15:0] mcnt = '0;
  logic [2*W-1:0] q[$];
  logic [2*W-1:0] expq[$];
  logic prev_sclk = 1'b0;
  logic prev_ws = 1'b0;
  logic [W-2:0] acc = '0;
  logic [W-1:0] dec_left = '0;

  always @(negedge clk) begin
    logic uf_exp;
    logic [W-1:0] word;
    logic [15:0] cnt_exp;
    uf_exp = 1'b0;
    if (!rst_n) begin
      c = 0; cur_k = -1; en_last = 1'b0; mcnt = '0; q.delete(); expq.delete();
      prev_sclk = 1'b0; prev_ws = 1'b0; acc = '0;
      chk("rst_sclk", i2s_sclk, 0); chk("rst_ws", i2s_ws, 0); chk("rst_sd", i2s_sd, 0);
      chk("rst_ready", ing_ready, 0); chk("rst_uf", sr_underflow, 0);
      chk("rst_cnt", sr_underflow_cnt, 0);
    end else begin
      if (!s_en) begin
        c = 0; cur_k = -1; en_last = 1'b0; q.delete(); expq.delete();
        prev_ws = 1'b0; acc = '0;
      end else begin
        en_last = 1'b1;
        c++;
        if (c % (2*D) == 0) begin
          cur_k = ((c / (2*D)) - 1) % (2*W);
          if (cur_k == 0) begin
            if (q.size() > 0) expq.push_back(q.pop_front());
            else begin
              expq.push_back('0);
              uf_exp = 1'b1;
            end
          end
        end
        if (s_push) q.push_back(s_pair);
      end
      if (s_clr) mcnt = '0;
      else if (uf_exp && mcnt != 16'hFFFF) mcnt++;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
      cnt_exp = mcnt;
`else
      cnt_exp = '0;
`endif
      chk("sclk", i2s_sclk, en_last ? (c / D) % 2 : 0);
      chk("ws", i2s_ws, (cur_k >= W));
      if (cur_k < 0) chk("sd_idle", i2s_sd, 0);
      chk("ready", ing_ready, en_last && (q.size() < DEPTH));
      chk("underflow", sr_underflow, uf_exp);
      chk("uf_cnt", sr_underflow_cnt, cnt_exp);
      // Receiver: a word ends on the bit sampled where WS changes
      if (i2s_sclk && !prev_sclk) begin
        if (i2s_ws != prev_ws) begin
          word = {acc, i2s_sd};
          if (!i2s_ws) begin
            chk("pair_avail", expq.size() != 0, 1);
            if (expq.size() != 0) chk("pair", {dec_left, word}, expq.pop_front());
            pairs++;
          end else begin
            dec_left = word;
          end
          acc = '0;
          prev_ws = i2s_ws;
        end else begin
          acc = {acc[W-3:0], i2s_sd};
        end
      end
      prev_sclk = i2s_sclk;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    logic acc_ok;
    acc_ok = 1'b0;
    ing_left = l; ing_right = r; ing_valid = 1'b1;
    for (int i = 0; i < 400 && !acc_ok; i++) begin
      acc_ok = ing_ready;
      tick();
    end
    chk("push_accept", acc_ok, 1);
    ing_valid = 1'b0;
  endtask

  initial begin
    int p0;
    logic cond;
    rst_n = 1'b0; cr_tx_enable = 1'b1; cr_underflow_clr = 1'b0;
    ing_valid = 1'b0; ing_left = '0; ing_right = '0;
    repeat (5) tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", ing_ready, 1);

    // Directed extreme pair
    push_pair(24'h800001, 24'h7FFFFE);
    repeat (400) tick();
    chk("pair_decoded", pairs > 0, 1);

    // Five back-to-back pushes right after a frame start
    cond = 1'b0;
    for (int i = 0; i < 400 && !cond; i++) begin tick(); cond = (cur_k == 1); end
    chk("wait_k1", cond, 1);
    for (int i = 0; i < 4; i++) push_pair(W'($urandom), W'($urandom));
    chk("ready_drop", ing_ready, 0);
    push_pair(W'($urandom), W'($urandom));

    // Idle: three underflow frames after a counter clear
    repeat (1152) tick();
    cr_underflow_clr = 1'b1; tick(); cr_underflow_clr = 1'b0;
    repeat (576) tick();
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    chk("uf_cnt_3", sr_underflow_cnt, 3);
`else
    chk("uf_cnt_3", sr_underflow_cnt, 0);
`endif

    // Random traffic
    for (int i = 0; i < 900; i++) begin
      ing_valid = ($urandom_range(0, 2) != 0);
      ing_left = W'($urandom); ing_right = W'($urandom);
      tick();
    end
    ing_valid = 1'b0;

    // Disable mid-frame at k=30 with data queued
    p0 = pairs;
    push_pair(W'($urandom), W'($urandom));
    push_pair(W'($urandom), W'($urandom));
    cond = 1'b0;
    for (int i = 0; i < 400 && !cond; i++) begin tick(); cond = (cur_k == 30); end
    chk("wait_k30", cond, 1);
    cr_tx_enable = 1'b0;
    tick();
    chk("dis_sclk", i2s_sclk, 0); chk("dis_ws", i2s_ws, 0); chk("dis_sd", i2s_sd, 0);
    chk("dis_ready", ing_ready, 0);
    repeat (10) tick();
    cr_tx_enable = 1'b1;
    repeat (600) tick();
    push_pair(W'($urandom), W'($urandom));
    repeat (400) tick();
    chk("pairs_after_reenable", pairs > p0, 1);

    // Clear coinciding with an underflow pulse
    cond = 1'b0;
    for (int i = 0; i < 400 && !cond; i++) begin
      tick();
      cond = ((c + 1) % (2*D) == 0) && ((((c + 1) / (2*D)) - 1) % (2*W) == 0) && (q.size() == 0);
    end
    chk("wait_frame_edge", cond, 1);
    cr_underflow_clr = 1'b1;
    tick();
    cr_underflow_clr = 1'b0;
    chk("clr_uf_pulse", sr_underflow, 1);
    chk("clr_wins", sr_underflow_cnt, 0);
    repeat (200) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
